if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_i drives all state, and rst_i clears all state immediately and independently of clk_i while low.
REQ-002 Port clk_i  input  1  system clock; all state updates on the rising edge.
REQ-003 Port rst_i  input  1  asynchronous active-low reset.
REQ-004 Port start_i  input  1  run enable; 0 freezes all state.
REQ-005 Port stall_i  input  1  load-use stall request from hazard detection.
REQ-006 Port flush_i  input  1  branch-taken indication from ID stage.
REQ-007 Port branch_target_i  input  32  branch target byte address from ID stage.
REQ-008 Port imem_data_i  input  32  instruction word returned combinationally for imem_addr_o.
REQ-009 Port imem_addr_o  output  32  instruction fetch byte address; always equals pc_o.
REQ-010 Port pc_o  output  32  current program counter.
REQ-011 Port ifid_pc_o  output  32  IF/ID register: PC of the held instruction.
REQ-012 Port ifid_instr_o  output  32  IF/ID register: held instruction word.
REQ-013 Port ifid_valid_o  output  1  IF/ID register holds a real instruction (0 = bubble).
REQ-014 Port stall_cnt_o  output  32  count of stalled cycles.
REQ-015 Port flush_cnt_o  output  32  count of flushed cycles.

Function
REQ-016 Each rising edge SHALL perform exactly one action, chosen in priority order: freeze (start_i=0), stall (stall_i=1), flush (flush_i=1), advance.
REQ-017 Freeze SHALL hold PC, the IF/ID register and both counters unchanged.
REQ-018 Stall SHALL hold PC and the IF/ID register, and SHALL increment stall_cnt_o; flush_i SHALL be ignored in that cycle and flush_cnt_o SHALL not change.
REQ-019 Flush SHALL load PC with {branch_target_i[31:2],2'b00} and load IF/ID with pc=0, instr=0, valid=0, and SHALL increment flush_cnt_o.
REQ-020 Advance SHALL load PC with PC+4 (modulo 2^32) and load IF/ID with pc=PC, instr=imem_data_i, valid=1.
REQ-021 PC arithmetic SHALL be 32-bit unsigned; 0xFFFFFFFC advances to 0x00000000 with no error indication.
REQ-022 Both counters SHALL saturate at 0xFFFFFFFF and SHALL not wrap.
REQ-023 Latency: an instruction fetched at PC=A in cycle n SHALL appear on ifid_instr_o/ifid_pc_o=A after edge n+1.
REQ-024 imem_addr_o SHALL be a direct copy of the PC register, with no combinational path from any input.
REQ-025 A flush SHALL take effect on the first non-stall, non-freeze edge on which flush_i=1; a flush request that is held off by a stall is not latched and is not remembered.

Reset
REQ-026 While rst_i=0, pc_o, ifid_pc_o, ifid_instr_o, stall_cnt_o and flush_cnt_o SHALL be 0 and ifid_valid_o SHALL be 0, including when asserted mid-operation between clock edges.
REQ-027 After rst_i rises, the first advance edge SHALL fetch address 0x00000000.

Verification
REQ-028 Reset, start_i=1, no stall/flush, imem returns 0x00A00093 at address 0 -> after edge 1: pc_o=4, ifid_pc_o=0, ifid_instr_o=0x00A00093, ifid_valid_o=1.
REQ-029 PC=8 with stall_i=1 and flush_i=1 for 2 edges -> pc_o stays 8, IF/ID unchanged, stall_cnt_o=2, flush_cnt_o=0.
REQ-030 PC=12, flush_i=1, branch_target_i=0x00000043 -> pc_o=0x40, ifid_valid_o=0, ifid_instr_o=0, flush_cnt_o=1.
REQ-031 start_i=0 for 3 edges with stall_i=1 -> pc_o, IF/ID and both counters unchanged.
REQ-032 PC forced to 0xFFFFFFFC then one advance -> pc_o=0, ifid_pc_o=0xFFFFFFFC.
REQ-033 rst_i pulled low mid-cycle with PC=0x20 and stall_cnt_o=5 -> all outputs 0 before the next clock edge; after release, the next fetch is at address 0.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-fetch stage bus: control inputs, instruction memory port,
// IF/ID register outputs and stall/flush statistics.
interface if_stage_if;
   logic        start_i;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] branch_target_i;
   logic [31:0] imem_data_i;
   logic [31:0] imem_addr_o;
   logic [31:0] pc_o;
   logic [31:0] ifid_pc_o;
   logic [31:0] ifid_instr_o;
   logic        ifid_valid_o;
   logic [31:0] stall_cnt_o;
   logic [31:0] flush_cnt_o;

   // Pipeline / hazard side that drives the fetch stage.
   modport master (
      output start_i, stall_i, flush_i, branch_target_i, imem_data_i,
      input  imem_addr_o, pc_o, ifid_pc_o, ifid_instr_o, ifid_valid_o,
             stall_cnt_o, flush_cnt_o
   );

   // The fetch stage itself.
   modport slave (
      input  start_i, stall_i, flush_i, branch_target_i, imem_data_i,
      output imem_addr_o, pc_o, ifid_pc_o, ifid_instr_o, ifid_valid_o,
             stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and
// saturating stall/flush cycle counters.
module if_stage (
   input  logic     clk_i,
   input  logic     rst_i,
   if_stage_if.slave bus
);

   typedef enum logic [1:0] {
      ACT_FREEZE,
      ACT_STALL,
      ACT_FLUSH,
      ACT_ADVANCE
   } action_t;

   action_t     action;
   logic [31:0] pc;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        ifid_valid;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
   logic [31:0] target;

   // Branch targets are word aligned; the low two bits are dropped.
   assign target = bus.branch_target_i & ~32'h3;

   // Pick the single action for this edge in priority order.
   always_comb begin
      action = ACT_ADVANCE;
      if (!bus.start_i)
         action = ACT_FREEZE;
      else if (bus.stall_i)
         action = ACT_STALL;
      else if (bus.flush_i)
         action = ACT_FLUSH;
   end

   // PC, IF/ID register and counters; flush requests are never remembered.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pc         <= '0;
         ifid_pc    <= '0;
         ifid_instr <= '0;
         ifid_valid <= 1'b0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
      end else begin
         unique case (action)
            ACT_FREEZE: ;
            ACT_STALL: begin
               if (stall_cnt != '1)
                  stall_cnt <= stall_cnt + 32'd1;
            end
            ACT_FLUSH: begin
               pc         <= target;
               ifid_pc    <= '0;
               ifid_instr <= '0;
               ifid_valid <= 1'b0;
               if (flush_cnt != '1)
                  flush_cnt <= flush_cnt + 32'd1;
            end
            ACT_ADVANCE: begin
               pc         <= pc + 32'd4;
               ifid_pc    <= pc;
               ifid_instr <= bus.imem_data_i;
               ifid_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.imem_addr_o  = pc;
   assign bus.pc_o         = pc;
   assign bus.ifid_pc_o    = ifid_pc;
   assign bus.ifid_instr_o = ifid_instr;
   assign bus.ifid_valid_o = ifid_valid;
   assign bus.stall_cnt_o  = stall_cnt;
   assign bus.flush_cnt_o  = flush_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized
// control traffic compared against a cycle-level behavioural model.
module tb_if_stage;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   // Behavioural model state.
   logic [31:0] m_pc, m_ifid_pc, m_ifid_instr, m_sc, m_fc;
   logic        m_valid;

   if_stage_if bus ();

   if_stage dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents: a fixed hash of the address; word 0 is 0x00A00093.
   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h00A00093;
   endfunction

   always_comb bus.imem_data_i = imem_word(bus.imem_addr_o);

   // Apply one edge's worth of inputs (called at a negedge), advance the
   // model by the architectural rules, and return at the following negedge.
   task automatic step(input logic st, input logic sl, input logic fl,
                       input logic [31:0] tgt);
      bus.start_i         = st;
      bus.stall_i         = sl;
      bus.flush_i         = fl;
      bus.branch_target_i = tgt;
      @(posedge clk);
      if (!st) begin
         // frozen
      end else if (sl) begin
         if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      end else if (fl) begin
         m_pc         = {tgt[31:2], 2'b00};
         m_ifid_pc    = 0;
         m_ifid_instr = 0;
         m_valid      = 0;
         if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      end else begin
         m_ifid_pc    = m_pc;
         m_ifid_instr = imem_word(m_pc);
         m_valid      = 1;
         m_pc         = m_pc + 32'd4;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.start_i = 0; bus.stall_i = 0; bus.flush_i = 0; bus.branch_target_i = 0;
      m_pc = 0; m_ifid_pc = 0; m_ifid_instr = 0; m_valid = 0; m_sc = 0; m_fc = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.start_i = 1; bus.stall_i = 0; bus.flush_i = 0; bus.branch_target_i = 0;
      #3;
      checks++;
      if (bus.pc_o !== 32'd0 || bus.ifid_pc_o !== 32'd0 || bus.ifid_instr_o !== 32'd0 ||
          bus.ifid_valid_o !== 1'b0 || bus.stall_cnt_o !== 32'd0 || bus.flush_cnt_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_state pc=%h ifid_pc=%h instr=%h valid=%b sc=%h fc=%h (want all 0)",
                  bus.pc_o, bus.ifid_pc_o, bus.ifid_instr_o, bus.ifid_valid_o,
                  bus.stall_cnt_o, bus.flush_cnt_o);
      end
      @(negedge clk);
      do_reset();
   endtask

   task automatic test_first_fetch();
      do_reset();
      checks++;
      if (bus.imem_addr_o !== 32'd0) begin
         errors++;
         $display("FAIL first_addr got %h want 00000000", bus.imem_addr_o);
      end
      step(1, 0, 0, 0);
      checks++;
      if (bus.pc_o !== 32'd4 || bus.ifid_pc_o !== 32'd0 ||
          bus.ifid_instr_o !== 32'h00A00093 || bus.ifid_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL first_fetch pc=%h ifid_pc=%h instr=%h valid=%b want 4/0/00a00093/1",
                  bus.pc_o, bus.ifid_pc_o, bus.ifid_instr_o, bus.ifid_valid_o);
      end
      checks++;
      if (bus.imem_addr_o !== bus.pc_o || bus.imem_addr_o !== 32'd4) begin
         errors++;
         $display("FAIL imem_addr got %h want 00000004", bus.imem_addr_o);
      end
   endtask

   task automatic test_stall();
      do_reset();
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 1, 1, 32'h0000_0100);
      step(1, 1, 1, 32'h0000_0100);
      checks++;
      if (bus.pc_o !== 32'd8 || bus.ifid_pc_o !== 32'd4 ||
          bus.ifid_instr_o !== imem_word(32'd4) || bus.ifid_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL stall_hold pc=%h ifid_pc=%h instr=%h valid=%b want 8/4/%h/1",
                  bus.pc_o, bus.ifid_pc_o, bus.ifid_instr_o, bus.ifid_valid_o, imem_word(32'd4));
      end
      checks++;
      if (bus.stall_cnt_o !== 32'd2 || bus.flush_cnt_o !== 32'd0) begin
         errors++;
         $display("FAIL stall_counts sc=%0d fc=%0d want 2/0", bus.stall_cnt_o, bus.flush_cnt_o);
      end
      // The blocked flush must not be remembered.
      step(1, 0, 0, 0);
      checks++;
      if (bus.pc_o !== 32'd12 || bus.ifid_pc_o !== 32'd8 || bus.flush_cnt_o !== 32'd0) begin
         errors++;
         $display("FAIL stall_no_latch pc=%h ifid_pc=%h fc=%0d want c/8/0",
                  bus.pc_o, bus.ifid_pc_o, bus.flush_cnt_o);
      end
   endtask

   task automatic test_flush();
      do_reset();
      repeat (3) step(1, 0, 0, 0);
      step(1, 0, 1, 32'h0000_0043);
      checks++;
      if (bus.pc_o !== 32'h40 || bus.ifid_valid_o !== 1'b0 || bus.ifid_instr_o !== 32'd0 ||
          bus.ifid_pc_o !== 32'd0 || bus.flush_cnt_o !== 32'd1) begin
         errors++;
         $display("FAIL flush pc=%h valid=%b instr=%h ifid_pc=%h fc=%0d want 40/0/0/0/1",
                  bus.pc_o, bus.ifid_valid_o, bus.ifid_instr_o, bus.ifid_pc_o, bus.flush_cnt_o);
      end
      step(1, 0, 0, 0);
      checks++;
      if (bus.ifid_pc_o !== 32'h40 || bus.ifid_instr_o !== imem_word(32'h40) || bus.pc_o !== 32'h44) begin
         errors++;
         $display("FAIL flush_target_fetch ifid_pc=%h instr=%h pc=%h want 40/%h/44",
                  bus.ifid_pc_o, bus.ifid_instr_o, bus.pc_o, imem_word(32'h40));
      end
   endtask

   task automatic test_freeze();
      logic [31:0] pc0, ipc0, ins0, sc0, fc0;
      logic        v0;
      do_reset();
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      step(1, 0, 1, 32'h80);
      step(1, 0, 0, 0);
      pc0 = m_pc; ipc0 = m_ifid_pc; ins0 = m_ifid_instr; v0 = m_valid; sc0 = m_sc; fc0 = m_fc;
      repeat (3) step(0, 1, 1, 32'h1234_5678);
      checks++;
      if (bus.pc_o !== pc0 || bus.ifid_pc_o !== ipc0 || bus.ifid_instr_o !== ins0 ||
          bus.ifid_valid_o !== v0 || bus.stall_cnt_o !== sc0 || bus.flush_cnt_o !== fc0) begin
         errors++;
         $display("FAIL freeze pc=%h ifid_pc=%h instr=%h valid=%b sc=%0d fc=%0d want %h/%h/%h/%b/%0d/%0d",
                  bus.pc_o, bus.ifid_pc_o, bus.ifid_instr_o, bus.ifid_valid_o, bus.stall_cnt_o,
                  bus.flush_cnt_o, pc0, ipc0, ins0, v0, sc0, fc0);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      step(1, 0, 1, 32'hFFFF_FFFE);
      checks++;
      if (bus.pc_o !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_setup pc=%h want fffffffc", bus.pc_o);
      end
      step(1, 0, 0, 0);
      checks++;
      if (bus.pc_o !== 32'd0 || bus.ifid_pc_o !== 32'hFFFF_FFFC ||
          bus.ifid_instr_o !== imem_word(32'hFFFF_FFFC)) begin
         errors++;
         $display("FAIL wrap pc=%h ifid_pc=%h instr=%h want 0/fffffffc/%h",
                  bus.pc_o, bus.ifid_pc_o, bus.ifid_instr_o, imem_word(32'hFFFF_FFFC));
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      repeat (5) step(1, 1, 0, 0);
      repeat (8) step(1, 0, 0, 0);
      checks++;
      if (bus.pc_o !== 32'h20 || bus.stall_cnt_o !== 32'd5) begin
         errors++;
         $display("FAIL async_setup pc=%h sc=%0d want 20/5", bus.pc_o, bus.stall_cnt_o);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (bus.pc_o !== 32'd0 || bus.ifid_pc_o !== 32'd0 || bus.ifid_instr_o !== 32'd0 ||
          bus.ifid_valid_o !== 1'b0 || bus.stall_cnt_o !== 32'd0 || bus.flush_cnt_o !== 32'd0 ||
          bus.imem_addr_o !== 32'd0) begin
         errors++;
         $display("FAIL async_reset pc=%h ifid_pc=%h instr=%h valid=%b sc=%0d fc=%0d (want all 0)",
                  bus.pc_o, bus.ifid_pc_o, bus.ifid_instr_o, bus.ifid_valid_o,
                  bus.stall_cnt_o, bus.flush_cnt_o);
      end
      @(negedge clk);
      m_pc = 0; m_ifid_pc = 0; m_ifid_instr = 0; m_valid = 0; m_sc = 0; m_fc = 0;
      rst = 1'b1;
      step(1, 0, 0, 0);
      checks++;
      if (bus.ifid_pc_o !== 32'd0 || bus.ifid_instr_o !== 32'h00A00093 || bus.pc_o !== 32'd4) begin
         errors++;
         $display("FAIL async_refetch ifid_pc=%h instr=%h pc=%h want 0/00a00093/4",
                  bus.ifid_pc_o, bus.ifid_instr_o, bus.pc_o);
      end
   endtask

   task automatic test_random();
      logic        st, sl, fl;
      logic [31:0] tgt;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         st  = ($urandom_range(0, 9) != 0);
         sl  = ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 4) == 0);
         tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         step(st, sl, fl, tgt);
         checks++;
         if (bus.pc_o !== m_pc || bus.imem_addr_o !== m_pc || bus.ifid_pc_o !== m_ifid_pc ||
             bus.ifid_instr_o !== m_ifid_instr || bus.ifid_valid_o !== m_valid ||
             bus.stall_cnt_o !== m_sc || bus.flush_cnt_o !== m_fc) begin
            errors++;
            $display("FAIL random[%0d] got pc=%h ifid_pc=%h instr=%h v=%b sc=%0d fc=%0d want %h/%h/%h/%b/%0d/%0d",
                     i, bus.pc_o, bus.ifid_pc_o, bus.ifid_instr_o, bus.ifid_valid_o,
                     bus.stall_cnt_o, bus.flush_cnt_o, m_pc, m_ifid_pc, m_ifid_instr,
                     m_valid, m_sc, m_fc);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_first_fetch();
      test_stall();
      test_flush();
      test_freeze();
      test_wrap();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
